// File: rtl/soc_system_hps_read_fifo.sv
// Show-ahead sample FIFO read by the HPS one word per strobe edge on ctrl_in[0].
// Optional macro SOC_HPS_READ_FIFO_TOGGLE_EN: both strobe edges pop (toggle mode).
module soc_system_hps_read_fifo #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            ctrl_in,
    input  logic                  wr_valid,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_empty,
    output logic [DEPTH_LOG2:0]   rd_count,
    output logic [7:0]            status
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    function automatic logic [DEPTH_LOG2-1:0] ptr_inc(input logic [DEPTH_LOG2-1:0] p);
        return p + PTR_ONE;
    endfunction

    logic [1:0]             sync_r [SYNC_STAGES];
    logic                   strobe_d_r;
    logic [DATA_W-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [DEPTH_LOG2:0]    count_r, count_s;
    logic                   overflow_r, underflow_r, overflow_s, underflow_s;
    logic                   full_r, empty_r, wr_ready_r;
    logic [DATA_W-1:0]      rd_data_r;

    logic                   strobe_s, flush_s, flush_next_s, pop_pulse_s;
    logic                   push_s, pop_s;
    logic                   unused_ctrl_s;

    assign unused_ctrl_s = ^ctrl_in[7:2];
    assign strobe_s      = sync_r[SYNC_STAGES-1][0];
    assign flush_s       = sync_r[SYNC_STAGES-1][1];
    assign flush_next_s  = sync_r[SYNC_STAGES-2][1];

`ifdef SOC_HPS_READ_FIFO_TOGGLE_EN
    assign pop_pulse_s = strobe_s ^ strobe_d_r;
`else
    assign pop_pulse_s = strobe_s & ~strobe_d_r;
`endif

    // ready is registered, so it already reflects flush and full for this edge
    assign push_s = wr_valid & wr_ready_r;
    assign pop_s  = pop_pulse_s & (count_r != CNT_ZERO) & ~flush_s;

    // Synchronize strobe/flush bits and keep one extra strobe flop for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 2'b00;
            end
            strobe_d_r <= 1'b0;
        end else begin
            sync_r[0] <= ctrl_in[1:0];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            strobe_d_r <= strobe_s;
        end
    end

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        count_s     = count_r;
        overflow_s  = overflow_r;
        underflow_s = underflow_r;
        if (flush_s) begin
            wr_ptr_s    = PTR_ZERO;
            rd_ptr_s    = PTR_ZERO;
            count_s     = CNT_ZERO;
            overflow_s  = 1'b0;
            underflow_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
            if (wr_valid && !wr_ready_r) begin
                overflow_s = 1'b1;
            end else begin
                overflow_s = overflow_r;
            end
            if (pop_pulse_s && (count_r == CNT_ZERO)) begin
                underflow_s = 1'b1;
            end else begin
                underflow_s = underflow_r;
            end
        end
    end

    // Control state and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            wr_ready_r  <= 1'b1;
        end else begin
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
            full_r      <= (count_s == CNT_FULL);
            empty_r     <= (count_s == CNT_ZERO);
            wr_ready_r  <= (count_s != CNT_FULL) && !flush_next_s;
        end
    end

    // Sample storage, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Registered head word; holds the last value while the FIFO is empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (count_r != CNT_ZERO) begin
            rd_data_r <= mem_r[rd_ptr_r];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign wr_ready = wr_ready_r;
    assign rd_data  = rd_data_r;
    assign rd_empty = empty_r;
    assign rd_count = count_r;
    assign status   = {4'b0000, overflow_r, underflow_r, full_r, empty_r};

endmodule

// File: tb/tb_soc_system_hps_read_fifo.sv
// Directed bench for soc_system_hps_read_fifo at default parameters.
module tb_soc_system_hps_read_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  ctrl_in;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_empty;
    logic [4:0]  rd_count;
    logic [7:0]  status;

    int checks = 0;
    int errors = 0;

    soc_system_hps_read_fifo dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ctrl_in  (ctrl_in),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_empty (rd_empty),
        .rd_count (rd_count),
        .status   (status)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step(1);
        wr_valid = 1'b0;
    endtask

    // One pop request: rise/fall pulse normally, a single inversion in toggle mode
    task automatic strobe();
`ifdef SOC_HPS_READ_FIFO_TOGGLE_EN
        ctrl_in[0] = ~ctrl_in[0];
        step(8);
`else
        ctrl_in[0] = 1'b1;
        step(4);
        ctrl_in[0] = 1'b0;
        step(4);
`endif
    endtask

    // Pop request with a push landing on the same edge as the pop pulse
    task automatic strobe_with_push(input logic [15:0] d);
`ifdef SOC_HPS_READ_FIFO_TOGGLE_EN
        ctrl_in[0] = ~ctrl_in[0];
        step(2);
        push(d);
        step(5);
`else
        ctrl_in[0] = 1'b1;
        step(2);
        push(d);
        step(1);
        ctrl_in[0] = 1'b0;
        step(4);
`endif
    endtask

    initial begin
        reset_n  = 1'b0;
        ctrl_in  = 8'h00;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        step(2);
        check("reset_empty", 32'(rd_empty), 32'h1);
        check("reset_ready", 32'(wr_ready), 32'h1);
        check("reset_status", 32'(status), 32'h01);
        check("reset_count", 32'(rd_count), 32'h0);
        check("reset_data", 32'(rd_data), 32'h0);
        reset_n = 1'b1;
        step(1);

        // three pushes, no strobe
        push(16'h1111);
        check("first_push_empty", 32'(rd_empty), 32'h0);
        check("first_push_count", 32'(rd_count), 32'h1);
        push(16'h2222);
        check("show_ahead_data", 32'(rd_data), 32'h1111);
        push(16'h3333);
        step(1);
        check("three_count", 32'(rd_count), 32'h3);
        check("three_head", 32'(rd_data), 32'h1111);

        // pop through them
        strobe();
        check("pop1_data", 32'(rd_data), 32'h2222);
        check("pop1_count", 32'(rd_count), 32'h2);
        strobe();
        check("pop2_data", 32'(rd_data), 32'h3333);
        strobe();
        check("pop3_count", 32'(rd_count), 32'h0);
        check("pop3_status", 32'(status), 32'h01);
        check("pop3_hold", 32'(rd_data), 32'h3333);
        strobe();
        check("underflow_status", 32'(status), 32'h05);
        check("underflow_hold", 32'(rd_data), 32'h3333);
        check("underflow_ready", 32'(wr_ready), 32'h1);

        // fill to 16 and keep offering 2 more
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 16'hA000 + 16'(i);
            step(1);
        end
        wr_data = 16'hBEEF;
        step(2);
        wr_valid = 1'b0;
        check("full_ready", 32'(wr_ready), 32'h0);
        check("full_count", 32'(rd_count), 32'h10);
        check("full_status", 32'(status), 32'h0E);
        check("full_head", 32'(rd_data), 32'hA000);

        for (int i = 1; i <= 8; i++) begin
            strobe();
            check($sformatf("drain_data_%0d", i), 32'(rd_data), 32'hA000 + 32'(i));
        end
        check("half_count", 32'(rd_count), 32'h8);

        // push and pop on one edge at count 8
        strobe_with_push(16'hC000);
        check("simul8_count", 32'(rd_count), 32'h8);
        check("simul8_head", 32'(rd_data), 32'hA009);

        // flush while pushing
        ctrl_in[1] = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 16'hD000;
        step(3);
        check("flush_count", 32'(rd_count), 32'h0);
        check("flush_status", 32'(status), 32'h01);
        check("flush_ready", 32'(wr_ready), 32'h0);
        step(2);
        ctrl_in[1] = 1'b0;
        wr_valid   = 1'b0;
        step(3);
        check("post_flush_ready", 32'(wr_ready), 32'h1);
        check("post_flush_status", 32'(status), 32'h01);
        push(16'hE000);
        check("post_flush_count", 32'(rd_count), 32'h1);
        step(1);
        check("post_flush_data", 32'(rd_data), 32'hE000);
        check("post_flush_status2", 32'(status), 32'h00);

        // fill to 16 then push+pop on one edge: push is refused
        for (int i = 1; i < 16; i++) begin
            push(16'hF000 + 16'(i));
        end
        check("refill_count", 32'(rd_count), 32'h10);
        check("refill_status", 32'(status), 32'h02);
        strobe_with_push(16'hBAD0);
        check("simul16_count", 32'(rd_count), 32'hF);
        check("simul16_status", 32'(status), 32'h08);
        check("simul16_head", 32'(rd_data), 32'hF001);
        check("simul16_ready", 32'(wr_ready), 32'h1);

        // flush, load 4 words, write bit0 as 1,0,1,0 with junk in bits 7:2
        ctrl_in[1] = 1'b1;
        step(5);
        ctrl_in[1] = 1'b0;
        step(4);
        check("pre_toggle_count", 32'(rd_count), 32'h0);
        for (int i = 0; i < 4; i++) begin
            push(16'h4000 + 16'(i));
        end
        for (int i = 0; i < 4; i++) begin
            ctrl_in = (i % 2 == 0) ? 8'hFD : 8'hFC;
            step(6);
        end
        ctrl_in = 8'h00;
        step(4);
`ifdef SOC_HPS_READ_FIFO_TOGGLE_EN
        check("toggle_count", 32'(rd_count), 32'h0);
        check("toggle_status", 32'(status), 32'h01);
        check("toggle_data", 32'(rd_data), 32'h4003);
`else
        check("toggle_count", 32'(rd_count), 32'h2);
        check("toggle_status", 32'(status), 32'h00);
        check("toggle_data", 32'(rd_data), 32'h4002);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
